// File: rtl/byte_pack_pkg.sv
// Shared types and constants for the byte-to-word packer.
// Lane geometry is fixed here: 8-bit bytes, 4 lanes, 32-bit words.
package byte_pack_pkg;

  localparam int DATA_W     = 8;
  localparam int LANES      = 4;
  localparam int WORD_W     = DATA_W * LANES;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
  } pack_word_t;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/byte_pack_fifo2.sv
// 2-entry synchronous FIFO of packed words; head entry is always visible on rd_dat_o.
// Latency 1 cycle push-to-head; a push while full or a pop while empty is dropped.
module byte_pack_fifo2
  import byte_pack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  pack_word_t wr_dat_i,
  input  logic       pop_i,
  output pack_word_t rd_dat_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  pack_word_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign full_o   = (count_q == 2'd2);
  assign empty_o  = (count_q == 2'd0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;

  // Storage is cleared on reset so the head reads all-zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs accepted bytes into 32-bit little-endian words, flushing partial words on in_last.
// Latency 1 cycle to out_valid; in_ready drops while two words are queued, independent of out_ready.
module byte_word_packer
  import byte_pack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [LANES-1:0]  out_keep,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       word_count
);

  pack_state_e           state_q, state_d;
  logic [WORD_W-1:0]     acc_q, acc_d;
  logic [LANES-1:0]      keep_q, keep_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [15:0]           word_count_q;

  logic [WORD_W-1:0]     acc_merged;
  logic [LANES-1:0]      keep_merged;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  pack_word_t            push_word;
  pack_word_t            head_word;

  assign in_ready  = (state_q == FILL) && !fifo_full && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Lanes above the pointer are always zero in acc_q, so OR-ing places the byte.
  assign acc_merged  = acc_q | (WORD_W'(in_data) << (lane_q * DATA_W));
  assign keep_merged = keep_q | (LANES'(1) << lane_q);
  assign push        = accept && ((lane_q == LANE_IDX_W'(LANES - 1)) || in_last);
  assign push_word   = '{data: acc_merged, keep: keep_merged, last: in_last};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    keep_d  = keep_q;
    lane_d  = lane_q;
    if (accept) begin
      if (push) begin
        acc_d  = '0;
        keep_d = '0;
        lane_d = '0;
      end else begin
        acc_d  = acc_merged;
        keep_d = keep_merged;
        lane_d = lane_q + LANE_IDX_W'(1);
      end
    end
    unique case (state_q)
      FILL:    if (push && !pop && (fifo_count == 2'd1)) state_d = STALL;
      STALL:   if (pop) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      acc_q        <= '0;
      keep_q       <= '0;
      lane_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      keep_q  <= keep_d;
      lane_q  <= lane_d;
      if (pop) word_count_q <= word_count_q + 16'd1;
    end
  end

  byte_pack_fifo2 u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push),
    .wr_dat_i (push_word),
    .pop_i    (pop),
    .rd_dat_o (head_word),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign out_data   = head_word.data;
  assign out_keep   = head_word.keep;
  assign out_last   = head_word.last;
  assign word_count = word_count_q;

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Downstream consumer of the 8-bit registered data stage: collects consecutive accepted bytes into 32-bit little-endian words and presents them on a valid/ready output port. Partial words are flushed on an input `last` marker with a byte-enable mask. A 2-entry output queue decouples the byte side from back-pressure on the word side.

## Interface
- `DATA_W`, default 8: input byte width; fixed at 8 in this revision.
- `LANES`, default 4: bytes per output word; output width is `DATA_W*LANES` = 32.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `in_data`, input, 8: byte from the upstream register stage.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_last`, input, 1: the byte closes a frame; flush the word. Meaningful only with `in_valid`.
- `in_ready`, output, 1: packer can accept a byte this cycle.
- `out_data`, output, 32: packed word; byte k is in bits [8k+7:8k].
- `out_keep`, output, 4: lane k holds a valid byte.
- `out_last`, output, 1: the word ends a frame.
- `out_valid`, output, 1: the head of the output queue is valid.
- `out_ready`, input, 1: the consumer takes the word this cycle.
- `word_count`, output, 16: number of words popped since reset; wraps modulo 2^16.

## Operation
- Input accept: `in_valid && in_ready`. Output pop: `out_valid && out_ready`.
- Accumulator holds a 32-bit `acc` register, a 4-bit `acc_keep` mask and a 2-bit lane pointer `lane`, which runs 0 to 3.
- Accepted byte handling:
  - Write the byte to lane `lane` and set `acc_keep[lane]`.
  - If `lane==3` or `in_last`, the word completes: push `{acc with new byte, keep, in_last}` into the queue on the same edge, then clear `lane`, `acc_keep` and `acc` to 0.
  - Otherwise increment `lane`.
- FSM states:
  - FILL: `lane` is 0 to 3 and the queue is not full. Accept bytes.
  - STALL: queue count is 2. `in_ready` is 0 and `acc`/`lane` are held.
  - Transitions: FILL→STALL on a push that brings the count to 2 without a pop. STALL→FILL on any pop.
- `in_ready` is 1 when queue count < 2 and `reset` is low. It is driven from registers only; it does not depend combinationally on `out_ready`.
- Queue: 2-entry FIFO ordered oldest first. `out_*` show the head entry. A push and a pop in the same cycle leave the count unchanged.
- A `last` byte in lane 0 produces keep `0001`. A `last` byte in lane 3 produces keep `1111` with `out_last=1`.
- Lanes not written in a flushed word read as 0.
- `in_last` without `in_valid` is ignored.
- `word_count` increments on every pop.

## Timing
- Reset values, taking effect on the edge with `reset` high:
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`, `word_count=0`.
  - Queue empty, `lane=0`, `acc=0`.
  - `in_ready=0` while `reset` is high and 1 in the first cycle after.
- Reset mid-frame discards the partial `acc` and all queued words. No flush occurs.
- Latency: if the byte that completes a word is accepted at edge N and the queue was empty, `out_valid=1` with that word in the cycle after edge N. Latency is 1 cycle.
- Throughput is 1 byte per cycle sustained while `out_ready=1`, because one word per 4 cycles never fills the queue.
- Back-pressure: with `out_ready=0`, at most 2 complete words are queued plus a partial in `acc`. Further bytes are refused until a pop.
- `out_data`, `out_keep` and `out_last` are stable while `out_valid && !out_ready`.

## Structure
- Shared package `byte_pack_pkg`:
  - Constants `DATA_W`, `LANES`, `WORD_W`, `LANE_IDX_W`.
  - Typedef `pack_word_t` containing `{data, keep, last}`.
  - FSM state enum with FILL and STALL.
- One sub-module `byte_pack_fifo2`: a 2-entry synchronous FIFO of `pack_word_t` with push/pop/full/empty and count. The top module holds the accumulator, FSM and `word_count`.

## Test plan
- Reset then 4 bytes 0x11,0x22,0x33,0x44 with `out_ready=1` → one word `0x44332211`, keep `1111`, last 0, `out_valid` for 1 cycle starting the cycle after the 4th accept; `word_count=1`.
- Bytes 0xAA,0xBB with `in_last` on 0xBB → word `0x0000BBAA`, keep `0011`, last 1; the next byte lands in lane 0.
- `out_ready=0`, stream 12 bytes → 8 bytes accepted (2 queued words), `in_ready` drops to 0 after the 8th accept and stays 0; raising `out_ready` pops words in order and `in_ready` returns to 1 the cycle after the first pop.
- Simultaneous push and pop with 1 entry queued → count stays 1, order preserved, no lost or duplicated word.
- Assert `reset` after 2 bytes of a word plus 1 queued word → `out_valid=0` next cycle; a following 4-byte burst produces exactly one word with no residue of the old data.
- 65,537 words popped → `word_count` reads 1 (wrap).
